// File: rtl/scr_base_l3_bk_pkg.sv
// Shared definitions for the L3 bank tag-pipe front end: source encoding and opcode width.
package scr_base_l3_bk_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned NUM_SRC = 3;

    typedef enum logic [1:0] {
        SrcCore = 2'd0,
        SrcSnp  = 2'd1,
        SrcRef  = 2'd2
    } src_e;

    // Grant vectors are indexed by src_e; an empty grant maps to SrcCore.
    function automatic src_e gnt_to_src(input logic [NUM_SRC-1:0] gnt);
        if (gnt[SrcRef]) begin
            return SrcRef;
        end else if (gnt[SrcSnp]) begin
            return SrcSnp;
        end
        return SrcCore;
    endfunction

endpackage

// File: rtl/scr_base_l3_bk_tp_arb_pri.sv
// Fixed-priority select (refill > snoop > core) with a core override for starvation relief.
module scr_base_l3_bk_tp_arb_pri
    import scr_base_l3_bk_pkg::*;
(
    input  logic               ref_vd,
    input  logic               snp_vd,
    input  logic               core_vd,
    input  logic               override,
    output logic [NUM_SRC-1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (override && core_vd) begin
            gnt[SrcCore] = 1'b1;
        end else if (ref_vd) begin
            gnt[SrcRef] = 1'b1;
        end else if (snp_vd) begin
            gnt[SrcSnp] = 1'b1;
        end else if (core_vd) begin
            gnt[SrcCore] = 1'b1;
        end
    end

endmodule

// File: rtl/scr_base_l3_bk_tp_arb.sv
// Tag-pipe D0 arbiter: picks one of refill/snoop/core per cycle into a single output register,
// with a saturating starvation counter that lifts the core to top priority.
module scr_base_l3_bk_tp_arb
    import scr_base_l3_bk_pkg::*;
#(
    parameter int unsigned ADDR_W     = 40,
    parameter int unsigned ID_W       = 8,
    parameter int unsigned STARVE_LIM = 7
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ref_vd,
    output logic              ref_rdy,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic [OP_W-1:0]   ref_op,
    input  logic [ID_W-1:0]   ref_id,

    input  logic              snp_vd,
    output logic              snp_rdy,
    input  logic [ADDR_W-1:0] snp_addr,
    input  logic [OP_W-1:0]   snp_op,
    input  logic [ID_W-1:0]   snp_id,

    input  logic              core_vd,
    output logic              core_rdy,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [OP_W-1:0]   core_op,
    input  logic [ID_W-1:0]   core_id,

    output logic              d0_vd,
    input  logic              d0_rdy,
    output logic [ADDR_W-1:0] d0_addr,
    output logic [OP_W-1:0]   d0_op,
    output logic [ID_W-1:0]   d0_id,
    output logic [1:0]        d0_src
);

    localparam int unsigned CntW = (STARVE_LIM < 2) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [CntW-1:0] CntLim = CntW'(STARVE_LIM);

    logic               d0_vd_q,   d0_vd_d;
    src_e               d0_src_q,  d0_src_d;
    logic [CntW-1:0]    cnt_q,     cnt_d;
    logic [ADDR_W-1:0]  d0_addr_q, d0_addr_d;
    logic [OP_W-1:0]    d0_op_q,   d0_op_d;
    logic [ID_W-1:0]    d0_id_q,   d0_id_d;

    logic               load;
    logic               override;
    logic               any_gnt;
    logic [NUM_SRC-1:0] gnt;

    assign load     = !d0_vd_q || d0_rdy;
    assign override = (cnt_q == CntLim);
    assign any_gnt  = |gnt;

    scr_base_l3_bk_tp_arb_pri u_pri (
        .ref_vd   (ref_vd),
        .snp_vd   (snp_vd),
        .core_vd  (core_vd),
        .override (override),
        .gnt      (gnt)
    );

    // Ready is combinational on valid so sources never wait for ready before asserting valid.
    assign ref_rdy  = !rst && load && gnt[SrcRef];
    assign snp_rdy  = !rst && load && gnt[SrcSnp];
    assign core_rdy = !rst && load && gnt[SrcCore];

    always_comb begin
        d0_vd_d   = d0_vd_q;
        d0_src_d  = d0_src_q;
        d0_addr_d = d0_addr_q;
        d0_op_d   = d0_op_q;
        d0_id_d   = d0_id_q;
        cnt_d     = cnt_q;

        if (load) begin
            d0_vd_d = any_gnt;
            if (any_gnt) begin
                d0_src_d = gnt_to_src(gnt);
                if (gnt[SrcRef]) begin
                    d0_addr_d = ref_addr;
                    d0_op_d   = ref_op;
                    d0_id_d   = ref_id;
                end else if (gnt[SrcSnp]) begin
                    d0_addr_d = snp_addr;
                    d0_op_d   = snp_op;
                    d0_id_d   = snp_id;
                end else begin
                    d0_addr_d = core_addr;
                    d0_op_d   = core_op;
                    d0_id_d   = core_id;
                end
            end
        end

        // An idle core clears its debt even while D0 is stalled.
        if (!core_vd) begin
            cnt_d = '0;
        end else if (load) begin
            if (gnt[SrcCore]) begin
                cnt_d = '0;
            end else if (!override) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0_vd_q  <= 1'b0;
            d0_src_q <= SrcCore;
            cnt_q    <= '0;
        end else begin
            d0_vd_q  <= d0_vd_d;
            d0_src_q <= d0_src_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        d0_addr_q <= d0_addr_d;
        d0_op_q   <= d0_op_d;
        d0_id_q   <= d0_id_d;
    end

    assign d0_vd   = d0_vd_q;
    assign d0_src  = d0_src_q;
    assign d0_addr = d0_addr_q;
    assign d0_op   = d0_op_q;
    assign d0_id   = d0_id_q;

endmodule

// File: tb/tb_scr_base_l3_bk_tp_arb.sv
// Self-checking bench for the tag-pipe D0 arbiter: directed scenarios plus a randomized
// scoreboard run against a small reference model of grant and starvation behaviour.
module tb_scr_base_l3_bk_tp_arb;

    localparam int unsigned ADDR_W     = 40;
    localparam int unsigned ID_W       = 8;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned STARVE_LIM = 7;

    typedef struct packed {
        logic [1:0]        src;
        logic [ID_W-1:0]   id;
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
    } req_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ref_vd = 1'b0, snp_vd = 1'b0, core_vd = 1'b0;
    logic              ref_rdy, snp_rdy, core_rdy;
    logic [ADDR_W-1:0] ref_addr = '0, snp_addr = '0, core_addr = '0;
    logic [OP_W-1:0]   ref_op = '0, snp_op = '0, core_op = '0;
    logic [ID_W-1:0]   ref_id = '0, snp_id = '0, core_id = '0;
    logic              d0_vd;
    logic              d0_rdy = 1'b0;
    logic [ADDR_W-1:0] d0_addr;
    logic [OP_W-1:0]   d0_op;
    logic [ID_W-1:0]   d0_id;
    logic [1:0]        d0_src;

    int   checks = 0;
    int   errors = 0;
    req_t sb_q[$];

    always #5 clk = ~clk;

    scr_base_l3_bk_tp_arb #(
        .ADDR_W     (ADDR_W),
        .ID_W       (ID_W),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ref_vd    (ref_vd),
        .ref_rdy   (ref_rdy),
        .ref_addr  (ref_addr),
        .ref_op    (ref_op),
        .ref_id    (ref_id),
        .snp_vd    (snp_vd),
        .snp_rdy   (snp_rdy),
        .snp_addr  (snp_addr),
        .snp_op    (snp_op),
        .snp_id    (snp_id),
        .core_vd   (core_vd),
        .core_rdy  (core_rdy),
        .core_addr (core_addr),
        .core_op   (core_op),
        .core_id   (core_id),
        .d0_vd     (d0_vd),
        .d0_rdy    (d0_rdy),
        .d0_addr   (d0_addr),
        .d0_op     (d0_op),
        .d0_id     (d0_id),
        .d0_src    (d0_src)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ref_vd  = 1'b0;
        snp_vd  = 1'b0;
        core_vd = 1'b0;
        d0_rdy  = 1'b1;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ref_vd = 1'b1; snp_vd = 1'b1; core_vd = 1'b1; d0_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (d0_vd !== 1'b0) begin
            errors++; $display("FAIL reset_d0_vd: got %b want 0", d0_vd);
        end
        checks++;
        if (d0_src !== 2'd0) begin
            errors++; $display("FAIL reset_d0_src: got %0d want 0", d0_src);
        end
        checks++;
        if ({ref_rdy, snp_rdy, core_rdy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_rdy: got %b want 000", {ref_rdy, snp_rdy, core_rdy});
        end
        ref_vd = 1'b0; snp_vd = 1'b0; core_vd = 1'b0;
        #2 rst = 1'b0;
        next_cycle();
    endtask

    // All three sources valid: refill wins until the core's counter saturates.
    task automatic test_starve();
        logic       prev_v;
        logic [1:0] prev_src;
        logic [2:0] exp_rdy;
        prev_v   = 1'b0;
        prev_src = 2'd0;
        ref_id = 8'hA1; snp_id = 8'hB2; core_id = 8'hC3;
        ref_vd = 1'b1; snp_vd = 1'b1; core_vd = 1'b1; d0_rdy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp_rdy = (k == 8) ? 3'b001 : 3'b100;
            checks++;
            if ({ref_rdy, snp_rdy, core_rdy} !== exp_rdy) begin
                errors++;
                $display("FAIL starve_rdy cycle %0d: got %b want %b", k,
                         {ref_rdy, snp_rdy, core_rdy}, exp_rdy);
            end
            checks++;
            if (d0_vd !== prev_v) begin
                errors++; $display("FAIL starve_d0_vd cycle %0d: got %b want %b", k, d0_vd, prev_v);
            end
            if (prev_v) begin
                checks++;
                if (d0_src !== prev_src || d0_id !== ((prev_src == 2'd2) ? 8'hA1 : 8'hC3)) begin
                    errors++;
                    $display("FAIL starve_d0 cycle %0d: got src %0d id %h want src %0d", k,
                             d0_src, d0_id, prev_src);
                end
            end
            prev_v   = 1'b1;
            prev_src = (k == 8) ? 2'd0 : 2'd2;
            next_cycle();
        end
        drain();
    endtask

    // A stalled D0 holds its payload, grants nothing and freezes the starvation counter.
    task automatic test_stall();
        logic [2:0] exp_rdy;
        snp_id = 8'h33; core_id = 8'h44;
        snp_vd = 1'b1; core_vd = 1'b1; d0_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({ref_rdy, snp_rdy, core_rdy} !== 3'b010) begin
            errors++;
            $display("FAIL stall_first_rdy: got %b want 010", {ref_rdy, snp_rdy, core_rdy});
        end
        next_cycle();
        d0_rdy = 1'b0;
        snp_id = 8'h99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({ref_rdy, snp_rdy, core_rdy} !== 3'b000 || d0_vd !== 1'b1 ||
                d0_src !== 2'd1 || d0_id !== 8'h33) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got rdy %b vd %b src %0d id %h want 000 1 1 33",
                         i, {ref_rdy, snp_rdy, core_rdy}, d0_vd, d0_src, d0_id);
            end
            next_cycle();
        end
        d0_rdy = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            exp_rdy = (j == 7) ? 3'b001 : 3'b010;
            checks++;
            if ({ref_rdy, snp_rdy, core_rdy} !== exp_rdy) begin
                errors++;
                $display("FAIL stall_resume_rdy step %0d: got %b want %b", j,
                         {ref_rdy, snp_rdy, core_rdy}, exp_rdy);
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        req_t e;
        req_t got;
        int   npop;
        npop   = 0;
        d0_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            core_vd   = (i < 4);
            core_id   = ID_W'(i + 1);
            core_op   = OP_W'(i + 3);
            core_addr = ADDR_W'(40'h10_0000_0000 + i * 64);
            @(negedge clk);
            if (d0_vd && d0_rdy) begin
                got = '{src: d0_src, id: d0_id, op: d0_op, addr: d0_addr};
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; $display("FAIL b2b_pop: got id %h want no output", d0_id);
                end else begin
                    e = sb_q.pop_front();
                    npop++;
                    if (got !== e) begin
                        errors++;
                        $display("FAIL b2b_payload: got src %0d id %h want src %0d id %h",
                                 got.src, got.id, e.src, e.id);
                    end
                end
            end
            checks++;
            if (d0_vd !== (i >= 1 && i <= 4)) begin
                errors++; $display("FAIL b2b_d0_vd cycle %0d: got %b", i, d0_vd);
            end
            if (core_rdy) begin
                e = '{src: 2'd0, id: core_id, op: core_op, addr: core_addr};
                sb_q.push_back(e);
            end
            next_cycle();
        end
        checks++;
        if (npop != 4 || sb_q.size() != 0) begin
            errors++; $display("FAIL b2b_count: got %0d delivered want 4", npop);
        end
        sb_q.delete();
        drain();
    endtask

    task automatic test_reset_mid();
        core_id = 8'h77; core_vd = 1'b1; d0_rdy = 1'b0;
        next_cycle();
        core_vd = 1'b0; snp_vd = 1'b1; snp_id = 8'h11;
        @(negedge clk);
        checks++;
        if (d0_vd !== 1'b1 || d0_id !== 8'h77) begin
            errors++; $display("FAIL rstmid_pre: got vd %b id %h want 1 77", d0_vd, d0_id);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (d0_vd !== 1'b0 || {ref_rdy, snp_rdy, core_rdy} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_async: got vd %b rdy %b want 0 000", d0_vd,
                     {ref_rdy, snp_rdy, core_rdy});
        end
        next_cycle();
        rst = 1'b0;
        snp_vd = 1'b1; snp_id = 8'h5A; snp_op = 4'h6; snp_addr = 40'hAB_CDEF_0123; d0_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({ref_rdy, snp_rdy, core_rdy} !== 3'b010) begin
            errors++;
            $display("FAIL rstmid_first_grant: got %b want 010", {ref_rdy, snp_rdy, core_rdy});
        end
        next_cycle();
        snp_vd = 1'b0;
        @(negedge clk);
        checks++;
        if (d0_vd !== 1'b1 || d0_id !== 8'h5A || d0_src !== 2'd1 || d0_addr !== 40'hAB_CDEF_0123) begin
            errors++;
            $display("FAIL rstmid_deliver: got vd %b id %h src %0d want 1 5a 1", d0_vd, d0_id, d0_src);
        end
        drain();
    endtask

    task automatic test_random();
        logic       m_vd;
        logic       m_load;
        int         m_cnt;
        int         waits;
        logic [2:0] exp;
        req_t       e;
        req_t       got;
        m_vd  = 1'b0;
        m_cnt = 0;
        waits = 0;
        for (int c = 0; c < 3000; c++) begin
            ref_vd    = ($urandom_range(0, 9) < 5);
            snp_vd    = ($urandom_range(0, 9) < 5);
            core_vd   = ($urandom_range(0, 9) < 7);
            ref_id    = ID_W'($urandom);
            snp_id    = ID_W'($urandom);
            core_id   = ID_W'($urandom);
            ref_op    = OP_W'($urandom);
            snp_op    = OP_W'($urandom);
            core_op   = OP_W'($urandom);
            ref_addr  = ADDR_W'({$urandom, $urandom});
            snp_addr  = ADDR_W'({$urandom, $urandom});
            core_addr = ADDR_W'({$urandom, $urandom});
            d0_rdy    = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            m_load = !m_vd || d0_rdy;
            if (!m_load)                             exp = 3'b000;
            else if (m_cnt == STARVE_LIM && core_vd) exp = 3'b001;
            else if (ref_vd)                         exp = 3'b100;
            else if (snp_vd)                         exp = 3'b010;
            else if (core_vd)                        exp = 3'b001;
            else                                     exp = 3'b000;
            checks++;
            if ({ref_rdy, snp_rdy, core_rdy} !== exp) begin
                errors++;
                $display("FAIL rand_rdy cycle %0d: got %b want %b", c,
                         {ref_rdy, snp_rdy, core_rdy}, exp);
            end
            checks++;
            if (d0_vd !== m_vd) begin
                errors++; $display("FAIL rand_d0_vd cycle %0d: got %b want %b", c, d0_vd, m_vd);
            end
            if (d0_vd && d0_rdy) begin
                got = '{src: d0_src, id: d0_id, op: d0_op, addr: d0_addr};
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; $display("FAIL rand_pop cycle %0d: got id %h want no output", c, d0_id);
                end else begin
                    e = sb_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL rand_payload cycle %0d: got src %0d id %h want src %0d id %h",
                                 c, got.src, got.id, e.src, e.id);
                    end
                end
            end
            if (ref_rdy) begin
                e = '{src: 2'd2, id: ref_id, op: ref_op, addr: ref_addr};
                sb_q.push_back(e);
            end else if (snp_rdy) begin
                e = '{src: 2'd1, id: snp_id, op: snp_op, addr: snp_addr};
                sb_q.push_back(e);
            end else if (core_rdy) begin
                e = '{src: 2'd0, id: core_id, op: core_op, addr: core_addr};
                sb_q.push_back(e);
            end
            if (core_rdy) begin
                checks++;
                if (waits > STARVE_LIM) begin
                    errors++;
                    $display("FAIL rand_core_wait cycle %0d: got %0d lost slots want <= %0d",
                             c, waits, STARVE_LIM);
                end
                waits = 0;
            end else if (!core_vd) begin
                waits = 0;
            end else if (m_load) begin
                waits++;
            end
            if (!core_vd)           m_cnt = 0;
            else if (m_load) begin
                if (exp == 3'b001)  m_cnt = 0;
                else if (m_cnt < STARVE_LIM) m_cnt++;
            end
            if (m_load) m_vd = |exp;
            next_cycle();
        end
        ref_vd = 1'b0; snp_vd = 1'b0; core_vd = 1'b0; d0_rdy = 1'b1;
        @(negedge clk);
        if (d0_vd) begin
            got = '{src: d0_src, id: d0_id, op: d0_op, addr: d0_addr};
            checks++;
            if (sb_q.size() == 0) begin
                errors++; $display("FAIL rand_tail_pop: got id %h want no output", d0_id);
            end else begin
                e = sb_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL rand_tail_payload: got id %h want id %h", got.id, e.id);
                end
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL rand_leftover: got %0d undelivered want 0", sb_q.size());
        end
        next_cycle();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_starve();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
